// File: rtl/divisor_param.sv
// Parametrised sequential restoring divider with busy, divide-by-zero flag and done pulse.
// Define DIVISOR_SIGNED_EN to compile in per-operation two's-complement mode (selected by signo).
module divisor_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signo,
  input  logic [WIDTH-1:0] numerador,
  input  logic [WIDTH-1:0] denominador,
  output logic [WIDTH-1:0] cociente,
  output logic [WIDTH-1:0] resto,
  output logic             done,
  output logic             ocupado,
  output logic             div_cero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] cociente_q, cociente_d;
  logic [WIDTH-1:0] resto_q, resto_d;
  logic             done_q, done_d;
  logic             div_cero_q, div_cero_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] num_mag, den_mag;
  logic [WIDTH-1:0] q_fix, r_fix;
  logic [WIDTH:0]   trial, diff;

`ifdef DIVISOR_SIGNED_EN
  logic neg_n_q, neg_n_d;
  logic neg_d_q, neg_d_d;

  always_comb begin
    num_mag = (signo && numerador[WIDTH-1])   ? -numerador   : numerador;
    den_mag = (signo && denominador[WIDTH-1]) ? -denominador : denominador;
  end
`else
  logic signo_unused;
  assign signo_unused = signo;

  always_comb begin
    num_mag = numerador;
    den_mag = denominador;
  end
`endif

  // The dividend register doubles as the quotient: its MSB feeds the remainder, a quotient bit enters at the LSB.
  always_comb begin
    trial = {rem_q, dvd_q[WIDTH-1]};
    diff  = trial - {1'b0, den_q};
  end

  always_comb begin
    if (zero_q) begin
      q_fix = '1;
      r_fix = dvd_q;
    end else begin
      q_fix = dvd_q;
      r_fix = rem_q;
`ifdef DIVISOR_SIGNED_EN
      if (neg_n_q ^ neg_d_q) q_fix = -dvd_q;
      if (neg_n_q)           r_fix = -rem_q;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;
    den_d      = den_q;
    cociente_d = cociente_q;
    resto_d    = resto_q;
    done_d     = 1'b0;
    div_cero_d = div_cero_q;
    zero_d     = zero_q;
`ifdef DIVISOR_SIGNED_EN
    neg_n_d    = neg_n_q;
    neg_d_d    = neg_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          zero_d     = (denominador == '0);
          dvd_d      = (denominador == '0) ? numerador : num_mag;
          den_d      = den_mag;
          rem_d      = '0;
          cnt_d      = '0;
          div_cero_d = 1'b0;
`ifdef DIVISOR_SIGNED_EN
          neg_n_d    = signo & numerador[WIDTH-1];
          neg_d_d    = signo & denominador[WIDTH-1];
`endif
          state_d    = (denominador == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_STEP) state_d = FIX;
      end
      FIX: begin
        cociente_d = q_fix;
        resto_d    = r_fix;
        div_cero_d = zero_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      den_q      <= '0;
      cociente_q <= '0;
      resto_q    <= '0;
      done_q     <= 1'b0;
      div_cero_q <= 1'b0;
      zero_q     <= 1'b0;
`ifdef DIVISOR_SIGNED_EN
      neg_n_q    <= 1'b0;
      neg_d_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
      den_q      <= den_d;
      cociente_q <= cociente_d;
      resto_q    <= resto_d;
      done_q     <= done_d;
      div_cero_q <= div_cero_d;
      zero_q     <= zero_d;
`ifdef DIVISOR_SIGNED_EN
      neg_n_q    <= neg_n_d;
      neg_d_q    <= neg_d_d;
`endif
    end
  end

  assign cociente = cociente_q;
  assign resto    = resto_q;
  assign done     = done_q;
  assign div_cero = div_cero_q;
  assign ocupado  = (state_q != IDLE);

endmodule
